// File: rtl/fetch_sequencer_pkg.sv
// ============================================================================
// Module  : fetch_sequencer_pkg
// Brief   : State encoding, skip opcodes and width defaults for fetch_sequencer
// Revision: 1.0
// ============================================================================
`default_nettype none

package fetch_sequencer_pkg;

    localparam int c_PC_WIDTH_DEF    = 8;
    localparam int c_INSTR_WIDTH_DEF = 8;

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_FETCH = 2'd1;
    localparam logic [1:0] c_ST_LATCH = 2'd2;
    localparam logic [1:0] c_ST_EXEC  = 2'd3;

    localparam logic [3:0] OPC_SNZA = 4'd8;
    localparam logic [3:0] OPC_SNZS = 4'd9;

    function automatic logic is_skip_op(input logic [3:0] op);
        return (op == OPC_SNZA) || (op == OPC_SNZS);
    endfunction

endpackage

`default_nettype wire

// File: rtl/pc_reg.sv
// ============================================================================
// Module  : pc_reg
// Brief   : Program counter with +1/+2 advance, wraps modulo 2^PC_WIDTH
// Revision: 1.0
// ============================================================================
`default_nettype none

module pc_reg
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_WIDTH = c_PC_WIDTH_DEF
) (
    input  logic                CLK,
    input  logic                RST,
    input  logic                en,
    input  logic                inc2,
    output logic [PC_WIDTH-1:0] pc
);

    logic [PC_WIDTH-1:0] r_pc;
    logic [PC_WIDTH-1:0] w_step;

    assign w_step = inc2 ? PC_WIDTH'(2) : PC_WIDTH'(1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_pc <= '0;
        end else if (en) begin
            r_pc <= r_pc + w_step;
        end
    end

    assign pc = r_pc;

endmodule

`default_nettype wire

// File: rtl/fetch_sequencer.sv
// ============================================================================
// Module  : fetch_sequencer
// Brief   : Three-cycle FETCH/LATCH/EXEC instruction sequencer with skip support
// Revision: 1.0
// ============================================================================
`default_nettype none

module fetch_sequencer
    import fetch_sequencer_pkg::*;
#(
    parameter int PC_WIDTH    = c_PC_WIDTH_DEF,
    parameter int INSTR_WIDTH = c_INSTR_WIDTH_DEF
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   run,
    output logic [PC_WIDTH-1:0]    mem_addr,
    output logic                   mem_rd,
    input  logic [INSTR_WIDTH-1:0] mem_data,
    input  logic                   skip,
    output logic [3:0]             opcode,
    output logic [INSTR_WIDTH-5:0] operand,
    output logic                   exec_en,
    output logic                   busy
);

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [INSTR_WIDTH-1:0] r_ir;
    logic                   w_exec;
    logic                   w_inc2;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE:  w_state_nxt = run ? c_ST_FETCH : c_ST_IDLE;
            c_ST_FETCH: w_state_nxt = c_ST_LATCH;
            c_ST_LATCH: w_state_nxt = c_ST_EXEC;
            c_ST_EXEC:  w_state_nxt = run ? c_ST_FETCH : c_ST_IDLE;
            default:    w_state_nxt = c_ST_IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Read data arrives the cycle after the FETCH strobe, i.e. during LATCH.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_ir <= '0;
        end else if (r_state == c_ST_LATCH) begin
            r_ir <= mem_data;
        end
    end

    assign opcode  = r_ir[INSTR_WIDTH-1 -: 4];
    assign operand = r_ir[INSTR_WIDTH-5:0];

    assign w_exec  = (r_state == c_ST_EXEC);
    assign w_inc2  = skip & is_skip_op(opcode);

    pc_reg #(
        .PC_WIDTH (PC_WIDTH)
    ) u_pc_reg (
        .CLK  (CLK),
        .RST  (RST),
        .en   (w_exec),
        .inc2 (w_inc2),
        .pc   (mem_addr)
    );

    assign mem_rd  = (r_state == c_ST_FETCH);
    assign exec_en = w_exec;
    assign busy    = (r_state != c_ST_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_fetch_sequencer.sv
// ============================================================================
// Module  : tb_fetch_sequencer
// Brief   : Directed and randomized checks of fetch_sequencer against a PC model
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_fetch_sequencer;

    logic       CLK;
    logic       RST;
    logic       run;
    logic [7:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_data;
    logic       skip;
    logic [3:0] opcode;
    logic [3:0] operand;
    logic       exec_en;
    logic       busy;

    logic [7:0] rom [256];
    logic [7:0] m_pc;
    logic [7:0] m_word;
    int         n_vec;
    int         n_err;

    fetch_sequencer #(
        .PC_WIDTH    (8),
        .INSTR_WIDTH (8)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .run      (run),
        .mem_addr (mem_addr),
        .mem_rd   (mem_rd),
        .mem_data (mem_data),
        .skip     (skip),
        .opcode   (opcode),
        .operand  (operand),
        .exec_en  (exec_en),
        .busy     (busy)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Synchronous program ROM: data appears the cycle after the read strobe.
    always @(posedge CLK) begin
        if (mem_rd) mem_data <= rom[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_rom();
        for (int i = 0; i < 256; i++) rom[i] = 8'h00;
    endtask

    task automatic reset_dut();
        run = 1'b0;
        RST = 1'b1;
        #1;
        RST = 1'b0;
        m_pc = 8'h00;
    endtask

    task automatic start_run();
        run = 1'b1;
        step();
    endtask

    // Called while the DUT is in FETCH; drop_at: 0 keep run, 1/2/3 drop in FETCH/LATCH/EXEC.
    task automatic do_instr(input logic sk, input int drop_at);
        m_word = rom[m_pc];
        check("fetch_rd", 32'(mem_rd), 32'd1);
        check("fetch_addr", 32'(mem_addr), 32'(m_pc));
        check("fetch_busy", 32'(busy), 32'd1);
        skip = 1'($urandom & 1);
        if (drop_at == 1) run = 1'b0;
        step();
        check("latch_rd", 32'(mem_rd), 32'd0);
        check("latch_exec", 32'(exec_en), 32'd0);
        skip = 1'($urandom & 1);
        if (drop_at == 2) run = 1'b0;
        step();
        check("exec_en", 32'(exec_en), 32'd1);
        check("exec_op", 32'(opcode), 32'(m_word[7:4]));
        check("exec_opnd", 32'(operand), 32'(m_word[3:0]));
        check("exec_rd", 32'(mem_rd), 32'd0);
        skip = sk;
        if (drop_at == 3) run = 1'b0;
        if (sk && (m_word[7:4] == 4'd8 || m_word[7:4] == 4'd9)) m_pc = m_pc + 8'd2;
        else m_pc = m_pc + 8'd1;
        step();
        if (drop_at != 0) begin
            check("idle_busy", 32'(busy), 32'd0);
            check("idle_rd", 32'(mem_rd), 32'd0);
            check("idle_exec", 32'(exec_en), 32'd0);
            check("idle_pc", 32'(mem_addr), 32'(m_pc));
            check("idle_op_hold", 32'(opcode), 32'(m_word[7:4]));
            check("idle_opnd_hold", 32'(operand), 32'(m_word[3:0]));
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        RST   = 1'b0;
        run   = 1'b0;
        skip  = 1'b0;
        m_pc  = 8'h00;
        clear_rom();

        // Reset before any clock edge
        #1 RST = 1'b1;
        #1;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_rd", 32'(mem_rd), 32'd0);
        check("rst_exec", 32'(exec_en), 32'd0);
        check("rst_pc", 32'(mem_addr), 32'd0);
        check("rst_op", 32'(opcode), 32'd0);
        RST = 1'b0;

        // Straight-line run
        rom[0] = 8'h01; rom[1] = 8'h12; rom[2] = 8'h23;
        step();
        step();
        check("idle_wait_busy", 32'(busy), 32'd0);
        start_run();
        do_instr(1'b1, 0);
        do_instr(1'b1, 0);
        do_instr(1'b1, 0);
        check("line_addr3", 32'(mem_addr), 32'd3);

        // Skip taken
        reset_dut(); clear_rom();
        rom[0] = 8'h80;
        start_run();
        do_instr(1'b1, 0);
        check("skip_taken", 32'(mem_addr), 32'd2);

        // Skip ignored for non-skip opcode, and skip low with SNZS
        reset_dut(); clear_rom();
        rom[0] = 8'h50;
        start_run();
        do_instr(1'b1, 0);
        check("skip_ign_lsh", 32'(mem_addr), 32'd1);
        reset_dut(); clear_rom();
        rom[0] = 8'h90;
        start_run();
        do_instr(1'b0, 0);
        check("skip_low_snzs", 32'(mem_addr), 32'd1);

        // Run drop in LATCH
        reset_dut(); clear_rom();
        rom[0] = 8'h12; rom[1] = 8'h9F;
        start_run();
        do_instr(1'b0, 2);
        step();
        step();
        check("drop_busy", 32'(busy), 32'd0);
        check("drop_rd", 32'(mem_rd), 32'd0);
        check("drop_pc", 32'(mem_addr), 32'd1);

        // Async reset mid-EXEC
        start_run();
        step();
        step();
        check("pre_rst_exec", 32'(exec_en), 32'd1);
        check("pre_rst_op", 32'(opcode), 32'd9);
        #2 RST = 1'b1;
        #1;
        check("mid_rst_exec", 32'(exec_en), 32'd0);
        check("mid_rst_rd", 32'(mem_rd), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_pc", 32'(mem_addr), 32'd0);
        check("mid_rst_op", 32'(opcode), 32'd0);
        RST = 1'b0;
        run = 1'b0;
        m_pc = 8'h00;
        step();
        check("post_rst_pc", 32'(mem_addr), 32'd0);
        check("post_rst_busy", 32'(busy), 32'd0);

        // Wrap at 0xFF with SNZS; skip stays high through 255 non-skip opcodes
        reset_dut(); clear_rom();
        rom[255] = 8'h9A;
        start_run();
        for (int i = 0; i < 256; i++) do_instr(1'b1, 0);
        check("wrap_addr", 32'(mem_addr), 32'd1);

        // Randomized program with random skip and random run drops
        reset_dut();
        for (int i = 0; i < 256; i++) begin
            rom[i] = 8'($urandom);
            if (($urandom & 3) == 0) rom[i][7:4] = (($urandom & 1) != 0) ? 4'd8 : 4'd9;
        end
        start_run();
        for (int n = 0; n < 200; n++) begin
            int d;
            d = int'($urandom_range(0, 5));
            if (d > 3) d = 0;
            do_instr(1'($urandom & 1), d);
            if (d != 0) begin
                int idle_n;
                idle_n = int'($urandom_range(0, 2));
                for (int k = 0; k < idle_n; k++) begin
                    skip = 1'($urandom & 1);
                    step();
                    check("rnd_idle_busy", 32'(busy), 32'd0);
                    check("rnd_idle_pc", 32'(mem_addr), 32'(m_pc));
                end
                start_run();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
